ft245_sched: RTL and testbench

- Command scheduler sitting between the FT245 FIFO wrapper and the FPGA register space.
- Sequences the wrapper's read and write requests and parses 2-byte host command frames into register reads and writes.
- Returns register read data to the host.
- Arbitrates the single USB TX path between register read responses and a streaming data source.

---
 rtl/ft245_sched.sv | 166 ++++++++++++++++
 tb/tb_ft245_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_sched.sv
// Command scheduler between the FT245 FIFO wrapper and the register space:
// parses 2-byte host frames, returns read data, and shares the TX path with a stream source.
module ft245_sched #(
  parameter int ADDR_W   = 7,
  parameter int IDLE_GAP = 3,
  parameter int TIMEOUT  = 65535
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic              _txe,
  input  logic              _rxf,
  input  logic              _wr,
  input  logic              _rd,
  output logic              _write_data,
  output logic              _read_data,
  output logic [7:0]        data_to_pc,
  input  logic [7:0]        data_to_fpga,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  input  logic              strm_valid,
  input  logic [7:0]        strm_data,
  output logic              strm_ready,
  output logic              frame_err
);

  localparam int GAP_W = $clog2(IDLE_GAP + 2);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RX_REQ, S_RX_CAP, S_REG_WR, S_REG_RD, S_RD_LAT, S_TX_RSP, S_TX_STRM
  } state_t;

  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              partial_q, partial_d;
  logic              pend_q, pend_d;
  logic [7:0]        rsp_q, rsp_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        dpc_q, dpc_d;
  logic              ferr_q, ferr_d;
  logic              to_hit, drop;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q   <= S_IDLE;
      gap_q     <= '0;
      to_q      <= '0;
      partial_q <= 1'b0;
      pend_q    <= 1'b0;
      rsp_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      dpc_q     <= '0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      to_q      <= to_d;
      partial_q <= partial_d;
      pend_q    <= pend_d;
      rsp_q     <= rsp_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      dpc_q     <= dpc_d;
      ferr_q    <= ferr_d;
    end
  end

  // A stale half frame is only abandoned while nothing is in flight on the wrapper.
  assign to_hit = partial_q && (to_q == TO_W'(TIMEOUT));
  assign drop   = to_hit && ((state_q == S_IDLE) || (state_q == S_RX_REQ && _rd));

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    to_d      = to_q;
    partial_d = partial_q;
    pend_d    = pend_q;
    rsp_d     = rsp_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dpc_d     = dpc_q;
    ferr_d    = ferr_q;
    if (gap_q != '0) gap_d = gap_q - GAP_W'(1);
    if (partial_q && !to_hit) to_d = to_q + TO_W'(1);
    if (drop) begin
      state_d   = S_IDLE;
      partial_d = 1'b0;
      ferr_d    = 1'b1;
      to_d      = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (gap_q == '0) begin
          if (pend_q && !_txe) begin
            state_d = S_TX_RSP;
            dpc_d   = rsp_q;
          end else if ((partial_q || !pend_q) && !_rxf) begin
            state_d = S_RX_REQ;
          end else if (strm_valid && !_txe && !partial_q) begin
            state_d = S_TX_STRM;
            dpc_d   = strm_data;
          end
        end
        S_RX_REQ: if (!_rd) begin
          state_d = S_RX_CAP;
          gap_d   = GAP_W'(IDLE_GAP);
        end
        S_RX_CAP: begin
          to_d = '0;
          if (partial_q) begin
            wdata_d = data_to_fpga;
            state_d = S_REG_WR;
          end else begin
            addr_d = data_to_fpga[ADDR_W-1:0];
            if (data_to_fpga[7]) begin
              state_d = S_REG_RD;
            end else begin
              partial_d = 1'b1;
              state_d   = S_IDLE;
            end
          end
        end
        S_REG_WR: begin
          partial_d = 1'b0;
          to_d      = '0;
          state_d   = S_IDLE;
        end
        S_REG_RD: state_d = S_RD_LAT;
        S_RD_LAT: begin
          rsp_d   = reg_rdata;
          pend_d  = 1'b1;
          state_d = S_IDLE;
        end
        S_TX_RSP: if (!_wr) begin
          pend_d  = 1'b0;
          gap_d   = GAP_W'(IDLE_GAP);
          state_d = S_IDLE;
        end
        S_TX_STRM: if (!_wr) begin
          gap_d   = GAP_W'(IDLE_GAP);
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Requests drop combinationally on the strobe so they never outlive the transfer.
  always_comb begin
    _read_data  = !((state_q == S_RX_REQ) && _rd);
    _write_data = !(((state_q == S_TX_RSP) || (state_q == S_TX_STRM)) && _wr);
    reg_we      = (state_q == S_REG_WR);
    reg_re      = (state_q == S_REG_RD);
    strm_ready  = (state_q == S_TX_STRM) && !_wr;
    data_to_pc  = dpc_q;
    reg_addr    = addr_q;
    reg_wdata   = wdata_q;
    frame_err   = ferr_q;
  end

endmodule

// File: tb/tb_ft245_sched.sv
// Bench for ft245_sched: wrapper/register/stream models, a frame-level reference model
// feeding expectation queues, and a monitor that pops and compares on DUT activity.
module tb_ft245_sched;
  localparam int ADDR_W = 7, IDLE_GAP = 3, TIMEOUT = 100;

  logic clk = 1'b0;
  logic _reset, _txe, _rxf, _wr, _rd;
  logic [7:0] data_to_fpga, reg_rdata, strm_data;
  logic strm_valid;
  logic _write_data, _read_data, reg_we, reg_re, strm_ready, frame_err;
  logic [7:0] data_to_pc, reg_wdata;
  logic [ADDR_W-1:0] reg_addr;

  ft245_sched #(.ADDR_W(ADDR_W), .IDLE_GAP(IDLE_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), ._reset(_reset), ._txe(_txe), ._rxf(_rxf), ._wr(_wr), ._rd(_rd),
    ._write_data(_write_data), ._read_data(_read_data), .data_to_pc(data_to_pc),
    .data_to_fpga(data_to_fpga), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .strm_valid(strm_valid),
    .strm_data(strm_data), .strm_ready(strm_ready), .frame_err(frame_err));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, strm_pops = 0;
  logic [7:0] rx_q[$], strm_q[$], exp_strm[$], exp_rsp[$], tx_log[$];
  logic [ADDR_W-1:0] exp_rd[$];
  logic [ADDR_W+7:0] exp_wr[$];
  logic [7:0] mem[128], model_mem[128];
  bit rx_hold = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic send_wr(input logic [6:0] a, input logic [7:0] d);
    rx_q.push_back({1'b0, a});
    rx_q.push_back(d);
    exp_wr.push_back({a, d});
    model_mem[a] = d;
  endtask

  task automatic send_rd(input logic [6:0] a);
    rx_q.push_back({1'b1, a});
    exp_rd.push_back(a);
    exp_rsp.push_back(model_mem[a]);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_wr.size() + exp_rd.size() + exp_rsp.size() + exp_strm.size() + rx_q.size()) != 0
           && t < 3000) begin
      @(negedge clk); t++;
    end
    chk("drain_done", 32'(exp_wr.size() + exp_rd.size() + exp_rsp.size() + exp_strm.size()), 0);
    repeat (8) @(negedge clk);
  endtask

  // Register space stub: read data valid the cycle after the address is presented.
  initial forever begin
    @(posedge clk);
    if (reg_we) mem[reg_addr] = reg_wdata;
    reg_rdata <= mem[reg_addr];
  end

  // FT245 wrapper model: answers requests with one-cycle strobes after a random delay.
  initial begin
    _rd = 1; _wr = 1; _rxf = 1; data_to_fpga = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (_rd == 1'b0) _rd = 1'b1;
      else if (!_read_data && !rx_hold && rx_q.size() > 0 && $urandom_range(1, 0) == 1) begin
        data_to_fpga = rx_q.pop_front();
        _rd = 1'b0;
      end
      if (_wr == 1'b0) _wr = 1'b1;
      else if (!_write_data && !_txe && $urandom_range(1, 0) == 1) _wr = 1'b0;
      _rxf = (rx_q.size() == 0);
    end
  end

  // Stream source: pops after the monitor sees strm_ready.
  initial begin
    int popped = 0;
    strm_valid = 1'b0; strm_data = 8'h00;
    forever begin
      @(negedge clk); #2;
      while (popped < strm_pops) begin
        void'(strm_q.pop_front());
        popped++;
      end
      strm_valid = (strm_q.size() > 0);
      strm_data  = (strm_q.size() > 0) ? strm_q[0] : 8'h00;
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic prev_req = 1'b0, req;
    logic [7:0] held = 8'h00;
    int last_strb = -100;
    logic [ADDR_W+7:0] w;
    forever begin
      @(negedge clk); #1;
      if (!_reset) prev_req = 1'b0;
      else begin
        if (!_read_data && !_write_data) begin
          errors++; $display("FAIL both_req actual=both_low expected=one_high");
        end
        req = !_read_data || !_write_data || !_rd || !_wr;
        if (req && !prev_req) begin
          chk("req_gap_ok", 32'(cyc - last_strb > IDLE_GAP), 1);
          held = data_to_pc;
        end
        if ((!_write_data || !_wr) && data_to_pc !== held) begin
          errors++; $display("FAIL tx_stable actual=%0h expected=%0h", data_to_pc, held);
        end
        if (!_rd || !_wr) last_strb = cyc;
        if (!_wr) begin
          tx_log.push_back(data_to_pc);
          if (strm_ready) begin
            strm_pops++;
            if (exp_strm.size() == 0) chk("strm_unexpected", 1, 0);
            else chk("strm_byte", data_to_pc, exp_strm.pop_front());
          end else begin
            if (exp_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
            else chk("rsp_byte", data_to_pc, exp_rsp.pop_front());
          end
        end else if (strm_ready) begin
          errors++; $display("FAIL strm_ready_no_wr actual=1 expected=0");
        end
        if (reg_we) begin
          if (exp_wr.size() == 0) chk("we_unexpected", {reg_addr, reg_wdata}, 0);
          else begin w = exp_wr.pop_front(); chk("reg_write", {reg_addr, reg_wdata}, w); end
        end
        if (reg_re) begin
          if (exp_rd.size() == 0) chk("re_unexpected", reg_addr, 0);
          else chk("reg_read_addr", reg_addr, exp_rd.pop_front());
        end
        prev_req = req;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t, base;
    for (int i = 0; i < 128; i++) begin
      mem[i] = 8'(i) ^ 8'h3F;
      model_mem[i] = 8'(i) ^ 8'h3F;
    end
    _reset = 1'b0; _txe = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_write_data", _write_data, 1);
    chk("rst_read_data", _read_data, 1);
    chk("rst_outs", {data_to_pc, reg_addr, reg_wdata, reg_we, reg_re, strm_ready, frame_err}, 0);
    @(negedge clk); _reset = 1'b1;

    // Single register write with TX blocked: no write request may appear.
    _txe = 1'b1;
    n = tx_log.size();
    send_wr(7'h05, 8'hA7);
    drain();
    chk("t1_no_tx", 32'(tx_log.size() - n), 0);

    // Register read: mem[3] holds 0x3C.
    _txe = 1'b0;
    send_rd(7'h03);
    drain();
    chk("t2_rsp_3c", tx_log[tx_log.size()-1], 8'h3C);

    // Pending response outranks queued stream bytes once TX space returns.
    _txe = 1'b1;
    send_wr(7'h07, 8'h55);
    send_rd(7'h07);
    t = 0;
    while ((exp_wr.size() + exp_rd.size()) != 0 && t < 500) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
    chk("t3_txe_blocks", _write_data, 1);
    strm_q.push_back(8'h11); exp_strm.push_back(8'h11);
    strm_q.push_back(8'h22); exp_strm.push_back(8'h22);
    repeat (4) @(negedge clk);
    base = tx_log.size();
    _txe = 1'b0;
    t = 0;
    do begin @(negedge clk); #1; t++; end while (_write_data && _wr && t < 50);
    chk("t3_rsp_latency_ok", 32'(t <= IDLE_GAP + 1), 1);
    drain();
    chk("t3_tx0", tx_log[base], 8'h55);
    chk("t3_tx1", tx_log[base+1], 8'h11);
    chk("t3_tx2", tx_log[base+2], 8'h22);

    // Random frames, stream traffic and TX back-pressure.
    for (int i = 0; i < 40; i++) begin
      _txe = ($urandom_range(3, 0) == 0);
      if ($urandom_range(1, 0) == 1) send_rd(7'($urandom_range(127, 0)));
      else send_wr(7'($urandom_range(127, 0)), 8'($urandom_range(255, 0)));
      if ($urandom_range(2, 0) == 0) begin
        logic [7:0] b = 8'($urandom_range(255, 0));
        strm_q.push_back(b); exp_strm.push_back(b);
      end
      repeat ($urandom_range(12, 0)) @(negedge clk);
    end
    _txe = 1'b0;
    drain();
    chk("rand_no_ferr", frame_err, 0);

    // Half frame left hanging past the timeout.
    rx_q.push_back(8'h10);
    repeat (TIMEOUT + 30) @(negedge clk);
    chk("t4_frame_err", frame_err, 1);
    send_wr(7'h10, 8'h01);
    drain();
    chk("t4_ferr_sticky", frame_err, 1);

    // Reset while a read request is outstanding.
    rx_hold = 1;
    rx_q.push_back(8'h40);
    t = 0;
    do begin @(negedge clk); #1; t++; end while (_read_data && t < 50);
    chk("t5_in_rx_req", _read_data, 0);
    _reset = 1'b0;
    #1;
    chk("t5_read_rel", _read_data, 1);
    chk("t5_write_rel", _write_data, 1);
    chk("t5_outs", {data_to_pc, reg_addr, reg_wdata, reg_we, reg_re, strm_ready, frame_err}, 0);
    rx_q.delete();
    rx_hold = 0;
    @(negedge clk); _reset = 1'b1;
    send_wr(7'h02, 8'hFF);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
